// File: rtl/rx_channel_pkg.sv
// Shared flit-geometry defines and the rx_channel package: handshake states,
// derived widths and a flit-field helper used by the channel and its FIFO.
`ifndef RX_CHANNEL_DEFINES
`define RX_CHANNEL_DEFINES
`define HDR_SZ     2
`define PL_SZ      10
`define ADDR_SZ    4
`define DIRECTIONS 5
`define RX_DEPTH   4
`endif

package rx_channel_pkg;

  localparam int unsigned RX_HDR_SZ  = `HDR_SZ;
  localparam int unsigned RX_PL_SZ   = `PL_SZ;
  localparam int unsigned RX_ADDR_SZ = `ADDR_SZ;
  localparam int unsigned RX_DIRS    = `DIRECTIONS;
  localparam int unsigned RX_DW      = RX_HDR_SZ + RX_PL_SZ + RX_ADDR_SZ;
  localparam int unsigned RX_DEPTH   = `RX_DEPTH;

  // Receiver side of the 4-phase link handshake.
  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

  // Destination address carried in the low bits of every flit.
  function automatic logic [RX_ADDR_SZ-1:0] flit_addr(input logic [RX_DW-1:0] flit);
    return flit[RX_ADDR_SZ-1:0];
  endfunction

endpackage

// File: rtl/rx_channel_sync_fifo.sv
// First-word-fall-through synchronous FIFO: the head entry is presented
// combinationally, and over/underflowing requests are ignored.
module sync_fifo
  import rx_channel_pkg::*;
#(
  parameter int unsigned DEPTH = RX_DEPTH,
  parameter int unsigned DW    = RX_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [DW-1:0]            din,
  input  logic                     rd_en,
  output logic [DW-1:0]            dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic          wr_fire;
  logic          rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign count   = count_q;

  // Storage is deliberately left out of reset; only the pointers qualify it.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= din;
    end
  end

  // DEPTH is a power of two, so natural pointer overflow is the mod-DEPTH wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      unique case ({wr_fire, rd_fire})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    if (!empty) begin
      dout = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/rx_channel.sv
// Router input channel: terminates one 4-phase req/ack link and buffers
// received flits in a FWFT FIFO for the downstream routing logic.
module rx_channel
  import rx_channel_pkg::*;
#(
  parameter int unsigned DEPTH = `RX_DEPTH,
  parameter int unsigned DW    = `HDR_SZ + `PL_SZ + `ADDR_SZ
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     link_req,
  input  logic [DW-1:0]            link_data,
  output logic                     link_ack,
  output logic [DW-1:0]            item_out,
  output logic                     empty,
  input  logic                     read,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  hs_state_e state_q;
  hs_state_e state_d;
  logic      capture;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Full is the registered FIFO flag, so a pop frees the slot one cycle later.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HS_IDLE: if (link_req && !full) state_d = HS_ACK;
      HS_ACK:  if (!link_req)         state_d = HS_IDLE;
      default:                        state_d = HS_IDLE;
    endcase
  end

  always_comb begin
    link_ack = 1'b0;
    capture  = 1'b0;
    unique case (state_q)
      HS_IDLE: capture  = link_req && !full;
      HS_ACK:  link_ack = 1'b1;
      default: ;
    endcase
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (capture),
    .din   (link_data),
    .rd_en (read),
    .dout  (item_out),
    .empty (empty),
    .full  (full),
    .count (count)
  );

endmodule

// File: doc/rx_channel.md
# rx_channel

Input channel stage of the router: terminates one incoming inter-router (or local-core) link with a 4-phase req/ack handshake and buffers received flits in a first-word-fall-through FIFO. It sits directly upstream of the routing/arbitration logic. That logic sees the head flit plus an empty flag, and pops with a one-cycle read strobe. One instance per direction (N, E, S, W, L).

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- DW, `HDR_SZ+`PL_SZ+`ADDR_SZ, flit width; the address field is bits [`ADDR_SZ-1:0].

Ports:
- clk  input  1  single clock.
- reset  input  1  asynchronous, active-high reset.
- link_req  input  1  sender request (4-phase), synchronous to clk.
- link_data  input  DW  flit from sender; stable while link_req=1.
- link_ack  output  1  receiver acknowledge, registered.
- item_out  output  DW  head flit; 0 when empty.
- empty  input-side status  output  1  FIFO empty.
- read  input  1  pop head flit this cycle.
- full  output  1  FIFO holds DEPTH flits.
- count  output  $clog2(DEPTH)+1  current occupancy.

## Operation
- Handshake FSM with 2 states, IDLE and ACK:
  - IDLE (link_ack=0): if link_req=1 and full=0, write link_data at wr_ptr and go to ACK. If full=1, stay in IDLE; the sender stalls holding req and data.
  - ACK (link_ack=1): wait for link_req=0, then go to IDLE.
  - Exactly one write per req pulse. A req held high while in ACK never causes a second write.
- FIFO behaviour:
  - item_out = mem[rd_ptr] combinationally when empty=0, otherwise 0.
  - read=1 with empty=1 is ignored: no pointer or count change.
  - read=1 with empty=0 advances rd_ptr mod DEPTH.
  - wr_ptr advances mod DEPTH on each write; both pointers wrap from DEPTH-1 to 0.
- Occupancy:
  - count is +1 on write only, −1 on read only, and unchanged on simultaneous write and read.
  - full = (count==DEPTH); empty = (count==0).
  - The write decision uses the registered full. Simultaneous read and write when full is impossible, because no write happens while full. Overflow and underflow cannot occur.
- Reset is asynchronous and may assert mid-operation. It forces state IDLE, link_ack=0, both pointers 0, count=0, empty=1, full=0, item_out=0. Buffered flits are discarded; memory contents are not reset.

## Timing
- A write occurs at the clk edge ending the IDLE cycle in which link_req=1 and full=0. link_ack rises at that same edge.
- Write-to-visibility latency is 1 cycle: empty drops and item_out shows the flit in the cycle after the capture edge, if the FIFO was empty.
- link_ack falls at the first edge after link_req is sampled low. Minimum handshake is 4 cycles per flit with a registered sender.
- A read is sampled at the edge. item_out presents the next entry, or 0 if the FIFO becomes empty, in the following cycle.
- A pop that takes the FIFO from full restores full=0 one cycle later. A pending req can then be captured on the next edge.

## Structure
- Shared defines file:
  - existing `HDR_SZ, `PL_SZ, `ADDR_SZ, `DIRECTIONS;
  - new `RX_DEPTH as the default for DEPTH.
- One sub-module: sync_fifo (DEPTH, DW; wr_en, din, rd_en, dout, empty, full, count).
- rx_channel holds the handshake FSM and instantiates sync_fifo.

## Test plan
- Reset, then one 4-phase transfer of 0x2A5 → link_ack=1 one cycle after req. empty=0 and item_out=0x2A5 the next cycle. count=1.
- DEPTH=4, 5 back-to-back transfers with no reads → 4 acks. full=1, count=4. The 5th req stays unacked. A single read makes the 5th get captured within 2 cycles, and count returns to 4.
- FIFO holding 2 flits, read held for 3 cycles → 2 pops in order. The third read is ignored: count=0, empty=1, item_out=0.
- Simultaneous write capture and read with count=2 → count stays 2, and FIFO order is preserved.
- 10 writes/reads interleaved at DEPTH=4 → pointer wrap exercised. Output order matches input order, and no duplicate is produced while req is held high in ACK.
- Reset asserted while in ACK with count=3 → link_ack, count, full and item_out go to 0 and empty=1 immediately, without waiting for a clock edge.
